// File: rtl/detector_pkg.sv
// detector_pkg: shared bin types, power-unit tag and result codes for the tone detector path
package detector_pkg;
  localparam int N_BINS = 4;
  typedef logic [1:0] bin_idx_t;
  typedef struct packed {
    logic     v;
    bin_idx_t bin;
  } pwr_tag_t;
  typedef enum logic [2:0] {
    RES_SILENCE = 3'd0,
    RES_BIN1    = 3'd1,
    RES_BIN2    = 3'd2,
    RES_BIN3    = 3'd3,
    RES_BIN4    = 3'd4
  } det_result_t;
endpackage

// File: rtl/power_bin_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational round-robin pick of one of four eligible bins, starting at ptr
module rr_arbiter4
  import detector_pkg::*;
(
  input  logic [N_BINS-1:0] eligible,
  input  bin_idx_t          ptr,
  output logic              gnt_valid,
  output bin_idx_t          gnt_idx
);
  bin_idx_t p1, p2, p3;
  // scan forward from ptr; 2-bit adds wrap past bin 3 back to bin 0
  always_comb begin
    p1 = ptr + 2'd1;
    p2 = ptr + 2'd2;
    p3 = ptr + 2'd3;
    gnt_valid = |eligible;
    gnt_idx = eligible[ptr] ? ptr : eligible[p1] ? p1 : eligible[p2] ? p2 : p3;
  end
endmodule

// File: rtl/power_bin_scheduler.sv
// power_bin_scheduler: shares one pipelined power unit among four Goertzel bins and collects per-bin results into frames
module power_bin_scheduler
  import detector_pkg::*;
#(
  parameter int Q_W           = 32,
  parameter int P_W           = 64,
  parameter int PWR_LAT       = 3,
  parameter int FRAME_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*Q_W-1:0]   q1,
  input  logic [4*Q_W-1:0]   q2,
  output logic [3:0]         ack,
  output logic               op_valid,
  output logic [Q_W-1:0]     op_q1,
  output logic [Q_W-1:0]     op_q2,
  input  logic [P_W-1:0]     res_power,
  output logic [P_W-1:0]     power_1,
  output logic [P_W-1:0]     power_2,
  output logic [P_W-1:0]     power_3,
  output logic [P_W-1:0]     power_4,
  output logic               advance1,
  output logic               advance2,
  output logic               advance3,
  output logic               advance4,
  output logic               frame_done,
  output logic               frame_partial
);
  localparam int CNT_W = $clog2(FRAME_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TIMEOUT - 2);
  logic [3:0]       ack_q, ack_d, adv_q, adv_d, mask_q, mask_d, mask_hit;
  bin_idx_t         ptr_q, ptr_d, op_bin_q, gnt_idx;
  logic             gnt_valid, op_valid_q, wb, complete, timeout;
  logic             done_pend_q, done_q, partial_q;
  logic [Q_W-1:0]   op_q1_q, op_q2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwr_tag_t         tag_q [PWR_LAT];
  logic [P_W-1:0]   pwr_q [N_BINS];
  rr_arbiter4 u_arb (
    .eligible  (req & ~ack_q),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );
  // grant bookkeeping, writeback decode and frame/timeout decisions
  always_comb begin
    ack_d = gnt_valid ? 4'b0001 << gnt_idx : 4'b0000;
    ptr_d = gnt_valid ? gnt_idx + 2'd1 : ptr_q;
    wb = tag_q[PWR_LAT-1].v;
    adv_d = wb ? 4'b0001 << tag_q[PWR_LAT-1].bin : 4'b0000;
    mask_hit = mask_q | adv_d;
    complete = wb && mask_hit == 4'hF;
    timeout = mask_q != 4'h0 && cnt_q == CNT_LAST && !complete;
    mask_d = (complete || timeout) ? 4'h0 : mask_hit;
    cnt_d = (complete || timeout || mask_q == 4'h0) ? '0 : cnt_q + CNT_W'(1);
  end
  // issue stage: register the granted bin's operands toward the power unit
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= '0;
      op_valid_q <= 1'b0;
      op_q1_q <= '0;
      op_q2_q <= '0;
      op_bin_q <= '0;
      ptr_q <= '0;
    end else begin
      ack_q <= ack_d;
      op_valid_q <= gnt_valid;
      ptr_q <= ptr_d;
      if (gnt_valid) begin
        op_q1_q <= q1[gnt_idx*Q_W +: Q_W];
        op_q2_q <= q2[gnt_idx*Q_W +: Q_W];
        op_bin_q <= gnt_idx;
      end
    end
  end
  // tag pipe tracks which bin each in-flight power result belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PWR_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{v: op_valid_q, bin: op_bin_q};
      for (int i = 1; i < PWR_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end
  // writeback, update mask, frame completion and timeout pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_BINS; i++) pwr_q[i] <= '0;
      adv_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      done_pend_q <= 1'b0;
      done_q <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_BINS; i++) if (adv_d[i]) pwr_q[i] <= res_power;
      adv_q <= adv_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      done_pend_q <= complete;
      done_q <= done_pend_q;
      partial_q <= timeout;
    end
  end
  assign ack = ack_q;
  assign op_valid = op_valid_q;
  assign op_q1 = op_q1_q;
  assign op_q2 = op_q2_q;
  assign power_1 = pwr_q[0];
  assign power_2 = pwr_q[1];
  assign power_3 = pwr_q[2];
  assign power_4 = pwr_q[3];
  assign {advance4, advance3, advance2, advance1} = adv_q;
  assign frame_done = done_q;
  assign frame_partial = partial_q;
endmodule

// File: tb/tb_power_bin_scheduler.sv
// tb_power_bin_scheduler: scoreboard bench for the shared power-unit scheduler
module tb_power_bin_scheduler;
  localparam int PWR_LAT = 3;
  localparam int WB_DELAY = PWR_LAT + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = 4'b0;
  logic [127:0] q1 = '0, q2 = '0;
  logic [3:0] ack, drop_mask = 4'hF;
  logic op_valid, advance1, advance2, advance3, advance4, frame_done, frame_partial;
  logic [31:0] op_q1, op_q2;
  logic [63:0] res_power, power_1, power_2, power_3, power_4, s1, s2, s3;
  logic [63:0] pw [4];
  logic [3:0] adv;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [1:0] bin; logic [63:0] p; int due;} exp_t;
  exp_t sb[$];
  exp_t e;

  power_bin_scheduler #(.Q_W(32), .P_W(64), .PWR_LAT(PWR_LAT), .FRAME_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .q1(q1), .q2(q2), .ack(ack),
    .op_valid(op_valid), .op_q1(op_q1), .op_q2(op_q2), .res_power(res_power),
    .power_1(power_1), .power_2(power_2), .power_3(power_3), .power_4(power_4),
    .advance1(advance1), .advance2(advance2), .advance3(advance3), .advance4(advance4),
    .frame_done(frame_done), .frame_partial(frame_partial)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sq(input logic [31:0] a);
    logic signed [63:0] x;
    x = {{32{a[31]}}, a};
    return x * x;
  endfunction

  // power unit model: q1^2 + q2^2 through three register stages
  always @(posedge clk) begin
    s1 <= sq(op_q1) + sq(op_q2);
    s2 <= s1;
    s3 <= s2;
  end
  assign res_power = s3;

  always_comb begin
    pw[0] = power_1;
    pw[1] = power_2;
    pw[2] = power_3;
    pw[3] = power_4;
    adv = {advance4, advance3, advance2, advance1};
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (reset) sb.delete();

  // scoreboard: push on issue, pop and compare on each advance pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (op_valid) begin
        checks++;
        if (!$onehot(ack)) begin
          errors++;
          $display("FAIL ack_onehot: ack=%b required one-hot with op_valid", ack);
        end
        for (int i = 0; i < 4; i++) if (ack[i]) begin
          checks++;
          if (op_q1 !== q1[i*32 +: 32] || op_q2 !== q2[i*32 +: 32]) begin
            errors++;
            $display("FAIL op_mux bin%0d: op_q1=%h op_q2=%h required %h %h", i, op_q1, op_q2, q1[i*32 +: 32], q2[i*32 +: 32]);
          end
          sb.push_back(exp_t'{2'(i), sq(q1[i*32 +: 32]) + sq(q2[i*32 +: 32]), cyc + WB_DELAY});
        end
      end else begin
        checks++;
        if (ack !== 4'b0) begin
          errors++;
          $display("FAIL ack_idle: ack=%b required 0000 without op_valid", ack);
        end
      end
      for (int i = 0; i < 4; i++) if (adv[i]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_advance bin%0d: got pulse at cycle %0d, required none", i, cyc);
        end else begin
          e = sb.pop_front();
          if (e.bin != 2'(i) || pw[i] !== e.p || e.due != cyc) begin
            errors++;
            $display("FAIL writeback: bin%0d power=%0d cycle=%0d required bin%0d power=%0d cycle=%0d", i, pw[i], cyc, e.bin, e.p, e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    req = req & ~(ack & drop_mask);
  endtask

  task automatic set_bin(input int b, input logic [31:0] a, input logic [31:0] c);
    q1[b*32 +: 32] = a;
    q2[b*32 +: 32] = c;
  endtask

  task automatic test_reset();
    req = 4'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (ack !== 4'b0 || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_issue: ack=%b op_valid=%b required 0000 0", ack, op_valid);
    end
    checks++;
    if (op_q1 !== 32'd0 || op_q2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_ops: op_q1=%h op_q2=%h required 0 0", op_q1, op_q2);
    end
    checks++;
    if (power_1 !== 64'd0 || power_2 !== 64'd0 || power_3 !== 64'd0 || power_4 !== 64'd0) begin
      errors++;
      $display("FAIL reset_power: %0d %0d %0d %0d required all 0", power_1, power_2, power_3, power_4);
    end
    checks++;
    if (adv !== 4'b0 || frame_done !== 1'b0 || frame_partial !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: adv=%b done=%b partial=%b required 0", adv, frame_done, frame_partial);
    end
  endtask

  task automatic test_single();
    int n;
    test_reset();
    drop_mask = 4'hF;
    set_bin(0, 32'd3, 32'd4);
    req = 4'b0001;
    tick();
    checks++;
    if (ack !== 4'b0001 || op_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: ack=%b op_valid=%b required 0001 1", ack, op_valid);
    end
    n = 0;
    while (!advance1 && n < 12) begin tick(); n++; end
    checks++;
    if (!advance1 || n != WB_DELAY || power_1 !== 64'd25) begin
      errors++;
      $display("FAIL single_result: advance1=%b after %0d cycles power_1=%0d required 1 after %0d power 25", advance1, n, power_1, WB_DELAY);
    end
    tick();
    checks++;
    if (advance1 !== 1'b0 || power_1 !== 64'd25) begin
      errors++;
      $display("FAIL single_pulse: advance1=%b power_1=%0d required 0 25", advance1, power_1);
    end
  endtask

  task automatic test_contention();
    int n;
    test_reset();
    drop_mask = 4'hF;
    for (int b = 0; b < 4; b++) set_bin(b, 32'(b + 1), -32'(b + 2));
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ack !== 4'b0001 << k) begin
        errors++;
        $display("FAIL contention_order step%0d: ack=%b required %b", k, ack, 4'b0001 << k);
      end
    end
    n = 0;
    while (!advance4 && n < 12) begin tick(); n++; end
    checks++;
    if (!advance4 || frame_done !== 1'b0 || power_4 !== 64'd41) begin
      errors++;
      $display("FAIL contention_adv4: advance4=%b frame_done=%b power_4=%0d required 1 0 41", advance4, frame_done, power_4);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL contention_frame_done: frame_done=%b required 1 one cycle after advance4", frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL contention_done_pulse: frame_done=%b required 0", frame_done);
    end
  endtask

  task automatic test_fairness();
    test_reset();
    drop_mask = 4'h0;
    set_bin(0, 32'd1, 32'd2);
    set_bin(2, 32'd3, 32'd5);
    req = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (ack !== ((k % 2) != 0 ? 4'b0100 : 4'b0001)) begin
        errors++;
        $display("FAIL fairness step%0d: ack=%b required %b", k, ack, (k % 2) != 0 ? 4'b0100 : 4'b0001);
      end
    end
    req = 4'b0;
    repeat (6) tick();
    drop_mask = 4'hF;
  endtask

  task automatic test_timeout();
    int n, kp, dones;
    test_reset();
    drop_mask = 4'hF;
    set_bin(0, 32'd1, 32'd1);
    set_bin(1, 32'd2, 32'd2);
    req = 4'b0011;
    n = 0;
    while (!advance1 && n < 12) begin tick(); n++; end
    checks++;
    if (!advance1) begin
      errors++;
      $display("FAIL timeout_first_adv: advance1=%b required 1 within 12 cycles", advance1);
    end
    kp = 0;
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (frame_done) dones++;
      if (frame_partial && kp == 0) kp = k;
    end
    checks++;
    if (kp != 15) begin
      errors++;
      $display("FAIL timeout_partial: partial at +%0d cycles required +15", kp);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL timeout_no_done: frame_done pulses=%0d required 0", dones);
    end
    checks++;
    if (power_1 !== 64'd2 || power_2 !== 64'd8) begin
      errors++;
      $display("FAIL timeout_retain: power_1=%0d power_2=%0d required 2 8", power_1, power_2);
    end
  endtask

  task automatic test_same_cycle();
    int n, partials, dones;
    test_reset();
    drop_mask = 4'hF;
    for (int b = 0; b < 4; b++) set_bin(b, 32'(b + 2), 32'(b));
    req = 4'b0111;
    n = 0;
    while (!advance1 && n < 12) begin tick(); n++; end
    checks++;
    if (!advance1) begin
      errors++;
      $display("FAIL edge_first_adv: advance1=%b required 1 within 12 cycles", advance1);
    end
    partials = 0;
    dones = 0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k == 10) req[3] = 1'b1;
      if (frame_partial) partials++;
      if (frame_done) dones++;
      if (k == 15) begin
        checks++;
        if (advance4 !== 1'b1 || frame_partial !== 1'b0) begin
          errors++;
          $display("FAIL edge_adv4: advance4=%b partial=%b required 1 0", advance4, frame_partial);
        end
      end
      if (k == 16) begin
        checks++;
        if (frame_done !== 1'b1 || frame_partial !== 1'b0) begin
          errors++;
          $display("FAIL edge_done: frame_done=%b partial=%b required 1 0", frame_done, frame_partial);
        end
      end
    end
    checks++;
    if (partials != 0 || dones != 1) begin
      errors++;
      $display("FAIL edge_mask_clear: partial pulses=%0d done pulses=%0d required 0 1", partials, dones);
    end
  endtask

  task automatic test_reset_mid();
    int n, stray;
    test_reset();
    drop_mask = 4'hF;
    set_bin(3, 32'd2, 32'd3);
    req = 4'b1000;
    n = 0;
    while (!advance4 && n < 12) begin tick(); n++; end
    checks++;
    if (!advance4 || power_4 !== 64'd13) begin
      errors++;
      $display("FAIL mid_setup: advance4=%b power_4=%0d required 1 13", advance4, power_4);
    end
    set_bin(0, 32'd5, 32'd5);
    set_bin(1, 32'd7, 32'd1);
    req = 4'b0011;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (power_1 !== 64'd0 || power_2 !== 64'd0 || power_3 !== 64'd0 || power_4 !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_power: %0d %0d %0d %0d required all 0", power_1, power_2, power_3, power_4);
    end
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (adv != 4'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_no_advance: stray advance cycles=%0d required 0", stray);
    end
    set_bin(0, 32'd6, 32'd8);
    req = 4'b0001;
    n = 0;
    while (!advance1 && n < 12) begin tick(); n++; end
    checks++;
    if (!advance1 || power_1 !== 64'd100) begin
      errors++;
      $display("FAIL mid_recover: advance1=%b power_1=%0d required 1 100", advance1, power_1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    repeat (6) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
